dot_product_seq: RTL and testbench
==================================

# dot_product_seq

Sequencing front end for the 16x16 shift-add multiplier `sequential_mult`. It accepts a burst of `len` unsigned operand pairs over a valid/ready stream and feeds each pair to the multiplier through its go/done handshake. It accumulates the 32-bit products into a wide accumulator and presents the dot product with a one-cycle valid pulse. It sits directly upstream of `sequential_mult` and owns all of that block's control inputs.

## Interface
- ACC_W, 40: accumulator/result width; legal range 32..48.
- LEN_W, 8: width of the pair-count input.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; also drives `sequential_mult` reset.
- start  in  1  begin a burst; sampled only in IDLE.
- len  in  LEN_W  number of pairs in the burst; sampled with start.
- a_valid  in  1  operand pair valid.
- a_ready  out  1  block accepts a pair this cycle.
- a_mer  in  16  multiplier operand.
- a_mand  in  16  multiplicand operand.
- m_mer  out  16  to multiplier `mer`; registered.
- m_mand  out  16  to multiplier `mand`; registered.
- m_go  out  1  to multiplier `go`.
- m_done  in  1  from multiplier `done`.
- m_product  in  32  from multiplier `product`.
- result  out  ACC_W  accumulated sum; registered.
- result_valid  out  1  one-cycle pulse when result is final.
- overflow  out  1  sticky carry-out of accumulator for current burst.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FETCH, LAUNCH, WAIT, ACK, DONE.
- IDLE:
  - start=1 and len!=0: clear acc, overflow and pair counter; go to FETCH.
  - start=1 and len==0: clear acc and overflow; go to DONE.
  - otherwise stay.
- FETCH:
  - a_ready=1, m_go=0.
  - On a_valid: register a_mer/a_mand into m_mer/m_mand, go to LAUNCH.
  - Otherwise stay; no timeout.
- LAUNCH: m_go=1 for exactly one cycle with m_mer/m_mand stable. The multiplier (idle) loads the operands at this edge. Go to WAIT.
- WAIT: m_go=0; stay until m_done=1, then go to ACK.
- ACK:
  - m_go=1 for one cycle; this returns the multiplier to idle.
  - Capture: acc <= acc + zero-extended m_product, mod 2^ACC_W.
  - overflow |= carry out.
  - Increment the pair counter.
  - Next state: DONE if counter+1==len, else FETCH.
- DONE: result_valid=1 for one cycle; go to IDLE.
- m_go is never high in two consecutive cycles. FETCH always separates ACK from the next LAUNCH, so the multiplier never re-launches on a stale go.
- m_mer/m_mand change only on a FETCH handshake.
- start in any non-IDLE state is ignored; len is latched at start and unaffected by later changes.
- All arithmetic is unsigned; no saturation.

## Timing
- Reset values:
  - State IDLE.
  - a_ready=0, m_go=0, m_mer=0, m_mand=0.
  - result=0, result_valid=0, overflow=0, busy=0.
- Reset mid-burst (any state): immediate return to reset values. The multiplier resets simultaneously; no partial result is emitted.
- a_ready is a combinational function of state only; no dependence on a_valid.
- Per-pair latency: FETCH (≥1, until a_valid), LAUNCH 1, WAIT, ACK 1.
- WAIT length is set by the multiplier, and the block relies only on m_done, never on a cycle count:
  - m_done first rises 49+popcount(mer) cycles after the LAUNCH cycle.
  - WAIT therefore occupies 49+popcount(mer) cycles.
- With a_valid held high, total burst latency from the start cycle to the result_valid cycle is sum over pairs of (52+popcount(mer)) + 1.
- len==0: result_valid in the second cycle after start, with result=0.
- result holds the final value after DONE until the next accepted start clears it. overflow likewise.

## Test plan
- len=1, pair (3,5), a_valid held → one m_go pulse at LAUNCH, result=15, result_valid high 1 cycle, overflow=0, busy low the cycle after.
- len=3, pairs (1,1), (0xFFFF,0xFFFF), (2,3) with a_valid toggling every other cycle → a_ready only in FETCH, result=0xFFFE0008, exactly 6 m_go pulses, never back-to-back.
- ACC_W=32, len=2, pairs (0xFFFF,0xFFFF) twice → result=0xFFFC0002, overflow=1. A following burst of len=1, (1,1) → result=1, overflow=0.
- len=0 with start → result_valid in the second cycle after start, result=0, no m_go, a_ready never asserted.
- Assert reset during WAIT of pair 2 of a len=4 burst → all outputs at reset values. A new burst len=1, (7,9) then yields result=63.
- Pulse start during WAIT with a different len → ignored; the burst completes with the original len and result.

Source files
------------

// File: rtl/dot_product_seq.sv
// Burst dot-product sequencer in front of the sequential_mult shift-add multiplier.
// Streams operand pairs into the multiplier and accumulates the 32-bit products.
module dot_product_seq #(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [15:0]      a_mer,
    input  logic [15:0]      a_mand,
    output logic [15:0]      m_mer,
    output logic [15:0]      m_mand,
    output logic             m_go,
    input  logic             m_done,
    input  logic [31:0]      m_product,
    output logic [ACC_W-1:0] result,
    output logic             result_valid,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAUNCH,
        S_WAIT,
        S_ACK,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic [15:0]        r_mer;
    logic [15:0]        r_mand;
    logic               r_go;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic               r_valid;

    logic [LEN_W-1:0]   w_cnt_nxt;
    logic [ACC_W:0]     w_prod;
    logic [ACC_W:0]     w_sum;

    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_prod    = {{(ACC_W-31){1'b0}}, m_product};
    assign w_sum     = {1'b0, r_acc} + w_prod;

    // go is asserted from the state that precedes LAUNCH/ACK so it is a flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_mer   <= '0;
            r_mand  <= '0;
            r_go    <= 1'b0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                        r_len <= len;
                        r_cnt <= '0;
                        if (len == '0) begin
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (a_valid) begin
                        r_mer   <= a_mer;
                        r_mand  <= a_mand;
                        r_go    <= 1'b1;
                        r_state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_go    <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (m_done) begin
                        r_go    <= 1'b1;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_go  <= 1'b0;
                    r_acc <= w_sum[ACC_W-1:0];
                    r_ovf <= r_ovf | w_sum[ACC_W];
                    r_cnt <= w_cnt_nxt;
                    if (w_cnt_nxt == r_len) begin
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_go    <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a_ready      = (r_state == S_FETCH);
    assign busy         = (r_state != S_IDLE);
    assign m_mer        = r_mer;
    assign m_mand       = r_mand;
    assign m_go         = r_go;
    assign result       = r_acc;
    assign result_valid = r_valid;
    assign overflow     = r_ovf;

endmodule

// File: tb/tb_dot_product_seq.sv
// Directed bench for dot_product_seq with a behavioural go/done multiplier model.
// Two instances (40-bit and 32-bit accumulators) share the same stimulus.
module tb_dot_product_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len_i = '0;
    logic        a_valid = 1'b0;
    logic [15:0] a_mer = '0;
    logic [15:0] a_mand = '0;
    logic        m_done;
    logic [31:0] m_product;

    logic        rdy_a, go_a, rv_a, ovf_a, busy_a;
    logic [15:0] mer_a, mand_a;
    logic [39:0] res_a;
    logic        rdy_b, go_b, rv_b, ovf_b, busy_b;
    logic [15:0] mer_b, mand_b;
    logic [31:0] res_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dot_product_seq #(.ACC_W(40), .LEN_W(8)) u_a (
        .clk(clk), .reset(reset), .start(start), .len(len_i),
        .a_valid(a_valid), .a_ready(rdy_a), .a_mer(a_mer), .a_mand(a_mand),
        .m_mer(mer_a), .m_mand(mand_a), .m_go(go_a), .m_done(m_done),
        .m_product(m_product), .result(res_a), .result_valid(rv_a),
        .overflow(ovf_a), .busy(busy_a)
    );

    dot_product_seq #(.ACC_W(32), .LEN_W(8)) u_b (
        .clk(clk), .reset(reset), .start(start), .len(len_i),
        .a_valid(a_valid), .a_ready(rdy_b), .a_mer(a_mer), .a_mand(a_mand),
        .m_mer(mer_b), .m_mand(mand_b), .m_go(go_b), .m_done(m_done),
        .m_product(m_product), .result(res_b), .result_valid(rv_b),
        .overflow(ovf_b), .busy(busy_b)
    );

    // multiplier model: done rises 49+popcount(mer) cycles after the go cycle
    logic       mb;
    logic [7:0] mcnt, mn;
    logic       mdone;
    logic [31:0] mprod;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mb <= 1'b0; mcnt <= '0; mn <= '0; mdone <= 1'b0; mprod <= '0;
        end else if (!mb && !mdone && go_a) begin
            mb    <= 1'b1;
            mcnt  <= 8'd1;
            mn    <= 8'(49 + $countones(mer_a));
            mprod <= {16'h0, mer_a} * {16'h0, mand_a};
        end else if (mb) begin
            mcnt <= mcnt + 8'd1;
            if (mcnt + 8'd1 == mn) begin
                mb    <= 1'b0;
                mdone <= 1'b1;
            end
        end else if (mdone && go_a) begin
            mdone <= 1'b0;
        end
    end
    assign m_done    = mdone;
    assign m_product = mprod;

    int go_cnt = 0, bb_cnt = 0, rdy_cnt = 0, ovl_cnt = 0;
    logic prev_go = 1'b0;
    always @(negedge clk) begin
        if (go_a) go_cnt <= go_cnt + 1;
        if (go_a && prev_go) bb_cnt <= bb_cnt + 1;
        if (rdy_a) rdy_cnt <= rdy_cnt + 1;
        if (rdy_a && go_a) ovl_cnt <= ovl_cnt + 1;
        prev_go <= go_a;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic go_start(input logic [7:0] l);
        @(posedge clk); #1;
        start = 1'b1;
        len_i = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc = 0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            cyc++;
            if (rv_a) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic feed(input string tag, input logic [15:0] mer,
                        input logic [15:0] mand);
        bit got;
        got = 1'b0;
        a_mer = mer;
        a_mand = mand;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            a_valid = ~a_valid;
            #1;
            if (rdy_a && a_valid) got = 1'b1;
        end
        chk(tag, 64'(got), 64'd1);
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    initial begin
        int cyc, g0, r0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_out", {rdy_a, go_a, rv_a, ovf_a, busy_a}, 64'd0);
        chk("rst_mer", {mer_a, mand_a}, 64'd0);
        chk("rst_res", res_a, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // len=1, (3,5), a_valid held
        a_mer = 16'd3; a_mand = 16'd5; a_valid = 1'b1;
        g0 = go_cnt;
        go_start(8'd1);
        wait_valid("t1_vld", cyc);
        a_valid = 1'b0;
        chk("t1_lat", 64'(cyc), 64'd55);
        chk("t1_res", res_a, 64'd15);
        chk("t1_ovf", 64'(ovf_a), 64'd0);
        @(negedge clk);
        chk("t1_pulse", {rv_a, busy_a}, 64'd0);
        chk("t1_hold", res_a, 64'd15);
        chk("t1_go", 64'(go_cnt - g0), 64'd2);

        // len=3 with a_valid toggling
        g0 = go_cnt;
        go_start(8'd3);
        feed("t2_f0", 16'd1, 16'd1);
        feed("t2_f1", 16'hFFFF, 16'hFFFF);
        feed("t2_f2", 16'd2, 16'd3);
        wait_valid("t2_vld", cyc);
        chk("t2_res", res_a, 64'hFFFE0008);
        chk("t2_go", 64'(go_cnt - g0), 64'd6);
        chk("t2_b2b", 64'(bb_cnt), 64'd0);
        chk("t2_rdygo", 64'(ovl_cnt), 64'd0);

        // 32-bit accumulator overflow vs 40-bit
        a_mer = 16'hFFFF; a_mand = 16'hFFFF; a_valid = 1'b1;
        go_start(8'd2);
        wait_valid("t3_vld", cyc);
        a_valid = 1'b0;
        chk("t3_res_a", res_a, 64'h1FFFC0002);
        chk("t3_ovf_a", 64'(ovf_a), 64'd0);
        chk("t3_res_b", res_b, 64'hFFFC0002);
        chk("t3_ovf_b", 64'(ovf_b), 64'd1);
        repeat (3) @(negedge clk);
        chk("t3_hold", {ovf_b, res_b}, {1'b1, 32'hFFFC0002});
        a_mer = 16'd1; a_mand = 16'd1; a_valid = 1'b1;
        go_start(8'd1);
        wait_valid("t3b_vld", cyc);
        a_valid = 1'b0;
        chk("t3b_res_b", res_b, 64'd1);
        chk("t3b_ovf_b", 64'(ovf_b), 64'd0);

        // len=0
        g0 = go_cnt; r0 = rdy_cnt;
        go_start(8'd0);
        wait_valid("t4_vld", cyc);
        chk("t4_lat", 64'(cyc), 64'd1);
        chk("t4_res", res_a, 64'd0);
        @(negedge clk);
        chk("t4_go", 64'(go_cnt - g0), 64'd0);
        chk("t4_rdy", 64'(rdy_cnt - r0), 64'd0);

        // reset during WAIT of pair 2
        a_mer = 16'd2; a_mand = 16'd3; a_valid = 1'b1;
        g0 = go_cnt;
        go_start(8'd4);
        for (int n = 0; n < 400 && (go_cnt - g0) < 3; n++) @(negedge clk);
        chk("t5_reach", 64'(go_cnt - g0), 64'd3);
        repeat (10) @(negedge clk);
        chk("t5_busy", 64'(busy_a), 64'd1);
        reset = 1'b1;
        #1;
        chk("t5_rst_out", {rdy_a, go_a, rv_a, ovf_a, busy_a}, 64'd0);
        chk("t5_rst_mer", {mer_a, mand_a}, 64'd0);
        chk("t5_rst_res", res_a, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        a_mer = 16'd7; a_mand = 16'd9;
        go_start(8'd1);
        wait_valid("t5_vld", cyc);
        a_valid = 1'b0;
        chk("t5_res", res_a, 64'd63);

        // start during WAIT is ignored
        a_mer = 16'd2; a_mand = 16'd3; a_valid = 1'b1;
        g0 = go_cnt;
        go_start(8'd2);
        for (int n = 0; n < 400 && (go_cnt - g0) < 1; n++) @(negedge clk);
        repeat (10) @(negedge clk);
        start = 1'b1; len_i = 8'd5;
        @(negedge clk);
        start = 1'b0; len_i = 8'd1;
        wait_valid("t6_vld", cyc);
        a_valid = 1'b0;
        chk("t6_res", res_a, 64'd12);
        chk("t6_go", 64'(go_cnt - g0), 64'd4);
        repeat (3) @(negedge clk);
        chk("t6_idle", 64'(busy_a), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
